// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if: edge pulse inputs, event handshake and overflow diagnostics bundle
interface edge_event_arbiter_if #(
  parameter int CHANNELS = 16,
  parameter int OVF_W    = 8
);
  localparam int CH_W = $clog2(CHANNELS);
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] en_rise;
  logic [CHANNELS-1:0] en_fall;
  logic                ev_valid;
  logic                ev_ready;
  logic [CH_W-1:0]     ev_ch;
  logic [1:0]          ev_type;
  logic                pending_any;
  logic [CHANNELS-1:0] ovf_flags;
  logic [OVF_W-1:0]    ovf_cnt;
  logic                ovf_clr;
  modport master (
    output rise, fall, en_rise, en_fall, ev_ready, ovf_clr,
    input  ev_valid, ev_ch, ev_type, pending_any, ovf_flags, ovf_cnt
  );
  modport slave (
    input  rise, fall, en_rise, en_fall, ev_ready, ovf_clr,
    output ev_valid, ev_ch, ev_type, pending_any, ovf_flags, ovf_cnt
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: latches edge pulses per channel and serves them round-robin over valid/ready
module edge_event_arbiter #(
  parameter int CHANNELS = 16,
  parameter int OVF_W    = 8
) (
  input logic                clk,
  input logic                rst,
  edge_event_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(CHANNELS);
  localparam int SW   = OVF_W + CH_W + 2;
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t              state_q;
  logic [CHANNELS-1:0] pend_r_q, pend_r_d, pend_f_q, pend_f_d;
  logic [CHANNELS-1:0] ovf_flags_q, ovf_flags_d;
  logic [OVF_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [CH_W-1:0]     ptr_q, ev_ch_q, win, idx;
  logic [1:0]          ev_type_q;
  logic [CHANNELS-1:0] req, set_r, set_f, ovf_r, ovf_f, clr;
  logic [SW-1:0]       ovf_sum;
  logic                found, load;
  assign req   = (pend_r_q & bus.en_rise) | (pend_f_q & bus.en_fall);
  assign set_r = bus.rise & bus.en_rise;
  assign set_f = bus.fall & bus.en_fall;
  assign load  = |req && (state_q == IDLE || bus.ev_ready);
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = CH_W'((int'(ptr_q) + k) % CHANNELS);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_comb begin
    clr         = load ? (CHANNELS'(1) << win) : '0;
    pend_r_d    = ((pend_r_q & ~clr) | set_r) & bus.en_rise;
    pend_f_d    = ((pend_f_q & ~clr) | set_f) & bus.en_fall;
    ovf_r       = set_r & pend_r_q & ~clr;
    ovf_f       = set_f & pend_f_q & ~clr;
    ovf_flags_d = (bus.ovf_clr ? '0 : ovf_flags_q) | ovf_r | ovf_f;
    ovf_sum     = (bus.ovf_clr ? '0 : SW'(ovf_cnt_q)) + SW'($countones(ovf_r)) + SW'($countones(ovf_f));
    ovf_cnt_d   = (ovf_sum > SW'({OVF_W{1'b1}})) ? '1 : ovf_sum[OVF_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ev_ch_q     <= '0;
      ev_type_q   <= '0;
      pend_r_q    <= '0;
      pend_f_q    <= '0;
      ovf_flags_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      pend_r_q    <= pend_r_d;
      pend_f_q    <= pend_f_d;
      ovf_flags_q <= ovf_flags_d;
      ovf_cnt_q   <= ovf_cnt_d;
      if (load) begin
        state_q   <= PRESENT;
        ev_ch_q   <= win;
        ev_type_q <= {pend_f_q[win] & bus.en_fall[win], pend_r_q[win] & bus.en_rise[win]};
        ptr_q     <= (win == CH_W'(CHANNELS - 1)) ? '0 : win + 1'b1;
      end else if (bus.ev_ready) begin
        state_q <= IDLE;
      end
    end
  end
  assign bus.ev_valid    = (state_q == PRESENT);
  assign bus.ev_ch       = ev_ch_q;
  assign bus.ev_type     = ev_type_q;
  assign bus.pending_any = |req;
  assign bus.ovf_flags   = ovf_flags_q;
  assign bus.ovf_cnt     = ovf_cnt_q;
endmodule
